// File: rtl/id_hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: tracks dests in EX/MEM/WB, raises stall.
// Ports: clk, rst(async low), cpu_en, id_* decode fields, ex_flush -> stall, busy, count.
module id_hazard_scoreboard #(
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_en,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic             id_rs_used,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rt_used,
  input  logic [4:0]       id_wr_addr,
  input  logic             id_wr_en,
  input  logic             ex_flush,
  output logic             id_shouldStall,
  output logic [2:0]       sb_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       vld;
    logic [4:0] addr;
  } slot_t;

  localparam logic CMP_WB = (WB_BYPASS == 0);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] pend;
  logic       rs_hit;
  logic       rt_hit;
  logic       stall;
  logic       take;

  // $0 is hardwired, so a write to it never blocks a reader
  assign pend[0] = ex_q.vld  && (ex_q.addr  != 5'd0);
  assign pend[1] = mem_q.vld && (mem_q.addr != 5'd0);
  assign pend[2] = wb_q.vld  && (wb_q.addr  != 5'd0);

  assign rs_hit =
    (pend[0] && (ex_q.addr == id_rs_addr)) ||
    (pend[1] && (mem_q.addr == id_rs_addr)) ||
    (CMP_WB && pend[2] && (wb_q.addr == id_rs_addr));

  assign rt_hit =
    (pend[0] && (ex_q.addr == id_rt_addr)) ||
    (pend[1] && (mem_q.addr == id_rt_addr)) ||
    (CMP_WB && pend[2] && (wb_q.addr == id_rt_addr));

  // a flush squashes ID, so it overrides any hazard
  assign stall = id_valid && !ex_flush &&
    ((id_rs_used && rs_hit) || (id_rt_used && rt_hit));

  assign take = id_valid && !ex_flush && !stall;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (cpu_en) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (take && id_wr_en) begin
        ex_d.vld  = 1'b1;
        ex_d.addr = id_wr_addr;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign id_shouldStall = stall;
  assign sb_busy        = pend;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Testbench for id_hazard_scoreboard: two instances (bypass/32b, no-bypass/4b)
// driven in lockstep and checked against a pending-writer list model.
module tb_id_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       cpu_en = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] rs = '0;
  logic       rs_used = 1'b0;
  logic [4:0] rt = '0;
  logic       rt_used = 1'b0;
  logic [4:0] wr = '0;
  logic       wr_en = 1'b0;
  logic       ex_flush = 1'b0;

  logic        stall_a, stall_b;
  logic [2:0]  busy_a, busy_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;

  // model: destination regs of older instrs, [0]=EX [1]=MEM [2]=WB, 0 = none
  int     qa[3];
  int     qb[3];
  longint mcnt_a;
  int     mcnt_b;

  id_hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .id_valid(id_valid),
    .id_rs_addr(rs), .id_rs_used(rs_used),
    .id_rt_addr(rt), .id_rt_used(rt_used),
    .id_wr_addr(wr), .id_wr_en(wr_en), .ex_flush(ex_flush),
    .id_shouldStall(stall_a), .sb_busy(busy_a), .stall_count(cnt_a)
  );

  id_hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .id_valid(id_valid),
    .id_rs_addr(rs), .id_rs_used(rs_used),
    .id_rt_addr(rt), .id_rt_used(rt_used),
    .id_wr_addr(wr), .id_wr_en(wr_en), .ex_flush(ex_flush),
    .id_shouldStall(stall_b), .sb_busy(busy_b), .stall_count(cnt_b)
  );

  // a reg is blocked if any of the first `depth` older writers targets it
  function automatic bit m_hit(int e, int m, int w, int depth, logic [4:0] a);
    int ai;
    ai = int'(a);
    return (ai != 0) && ((e == ai) || (m == ai) || ((depth == 3) && (w == ai)));
  endfunction

  function automatic bit m_stall(int e, int m, int w, int depth);
    return id_valid && !ex_flush &&
      ((rs_used && m_hit(e, m, w, depth, rs)) ||
       (rt_used && m_hit(e, m, w, depth, rt)));
  endfunction

  function automatic logic [2:0] m_busy(int e, int m, int w);
    return {w != 0, m != 0, e != 0};
  endfunction

  task automatic tick();
    bit sa, sb;
    int inc;
    sa = m_stall(qa[0], qa[1], qa[2], 2);
    sb = m_stall(qb[0], qb[1], qb[2], 3);
    inc = wr_en ? int'(wr) : 0;
    @(posedge clk);
    if (cpu_en) begin
      qa[2] = qa[1]; qa[1] = qa[0];
      qa[0] = (sa || ex_flush || !id_valid) ? 0 : inc;
      qb[2] = qb[1]; qb[1] = qb[0];
      qb[0] = (sb || ex_flush || !id_valid) ? 0 : inc;
      if (sa && mcnt_a < 64'hFFFF_FFFF) mcnt_a++;
      if (sb && mcnt_b < 15) mcnt_b++;
    end
    #1;
  endtask

  task automatic model_clear();
    qa = '{0, 0, 0};
    qb = '{0, 0, 0};
    mcnt_a = 0;
    mcnt_b = 0;
  endtask

  task automatic idle();
    id_valid = 1'b0; rs = '0; rs_used = 1'b0; rt = '0; rt_used = 1'b0;
    wr = '0; wr_en = 1'b0; ex_flush = 1'b0; cpu_en = 1'b1;
  endtask

  task automatic set_prod(input logic [4:0] d);
    idle();
    id_valid = 1'b1; wr = d; wr_en = 1'b1;
  endtask

  task automatic set_cons(input logic [4:0] s, input logic su,
                          input logic [4:0] t, input logic tu);
    idle();
    id_valid = 1'b1; rs = s; rs_used = su; rt = t; rt_used = tu;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      cpu_en = 1'($urandom); id_valid = 1'($urandom);
      rs = 5'($urandom); rs_used = 1'($urandom);
      rt = 5'($urandom); rt_used = 1'($urandom);
      wr = 5'($urandom); wr_en = 1'($urandom); ex_flush = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({stall_a, stall_b, busy_a, busy_b} !== 8'd0 || cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold got=%b%b %b %b %0d %0d exp=all zero",
                 stall_a, stall_b, busy_a, busy_b, cnt_a, cnt_b);
      end
    end
    idle();
    rst = 1'b1;
    set_prod(5'd12);
    tick();
    set_cons(5'd12, 1'b1, 5'd0, 1'b0);
    tick();
    checks++;
    if (stall_a !== 1'b1 || cnt_a !== 32'd1) begin
      failures++;
      $display("FAIL reset_pre_stall got=%b/%0d exp=1/1", stall_a, cnt_a);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({stall_a, stall_b, busy_a, busy_b} !== 8'd0 || cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_stall got=%b%b %b %b %0d %0d exp=all zero",
               stall_a, stall_b, busy_a, busy_b, cnt_a, cnt_b);
    end
    do_reset();
  endtask

  task automatic test_raw();
    bit         ea[4] = '{1, 1, 0, 0};
    bit         eb[4] = '{1, 1, 1, 0};
    logic [2:0] ba[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] bb[4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    do_reset();
    set_prod(5'd5);
    tick();
    set_cons(5'd5, 1'b1, 5'd0, 1'b0);
    wr = 5'd6; wr_en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stall_a !== ea[i] || stall_b !== eb[i]) begin
        failures++;
        $display("FAIL raw_stall[%0d] got=%b/%b exp=%b/%b", i, stall_a, stall_b, ea[i], eb[i]);
      end
      checks++;
      if (busy_a !== ba[i] || busy_b !== bb[i]) begin
        failures++;
        $display("FAIL raw_busy[%0d] got=%b/%b exp=%b/%b", i, busy_a, busy_b, ba[i], bb[i]);
      end
      tick();
    end
    checks++;
    if (cnt_a !== 32'd2 || cnt_b !== 4'd3) begin
      failures++;
      $display("FAIL raw_count got=%0d/%0d exp=2/3", cnt_a, cnt_b);
    end
  endtask

  task automatic test_rt_zero();
    do_reset();
    set_prod(5'd7);
    tick();
    set_cons(5'd7, 1'b0, 5'd7, 1'b1);
    #1;
    checks++;
    if (stall_a !== 1'b1 || stall_b !== 1'b1) begin
      failures++;
      $display("FAIL rt_only got=%b/%b exp=1/1", stall_a, stall_b);
    end
    rt_used = 1'b0;
    #1;
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      failures++;
      $display("FAIL unused_ops got=%b/%b exp=0/0", stall_a, stall_b);
    end
    do_reset();
    set_prod(5'd0);
    tick();
    checks++;
    if (busy_a !== 3'b000 || busy_b !== 3'b000) begin
      failures++;
      $display("FAIL zero_busy got=%b/%b exp=000/000", busy_a, busy_b);
    end
    set_cons(5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      failures++;
      $display("FAIL zero_read got=%b/%b exp=0/0", stall_a, stall_b);
    end
    do_reset();
    set_cons(5'd9, 1'b1, 5'd0, 1'b0);
    wr = 5'd9; wr_en = 1'b1;
    #1;
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      failures++;
      $display("FAIL self_dep got=%b/%b exp=0/0", stall_a, stall_b);
    end
    tick();
    checks++;
    if (stall_a !== 1'b1 || busy_a !== 3'b001) begin
      failures++;
      $display("FAIL self_dep_next got=%b/%b exp=1/001", stall_a, busy_a);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_prod(5'd3);
    tick();
    set_cons(5'd3, 1'b1, 5'd0, 1'b0);
    ex_flush = 1'b1;
    #1;
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b/%b exp=0/0", stall_a, stall_b);
    end
    tick();
    checks++;
    if (busy_a !== 3'b010 || busy_b !== 3'b010 || cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
      failures++;
      $display("FAIL flush_bubble got=%b/%b %0d/%0d exp=010/010 0/0",
               busy_a, busy_b, cnt_a, cnt_b);
    end
    ex_flush = 1'b0;
    #1;
    checks++;
    if (stall_a !== 1'b1 || stall_b !== 1'b1) begin
      failures++;
      $display("FAIL flush_release got=%b/%b exp=1/1", stall_a, stall_b);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_prod(5'd4);
    tick();
    set_cons(5'd4, 1'b1, 5'd0, 1'b0);
    tick();
    cpu_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (stall_a !== 1'b1 || stall_b !== 1'b1 || busy_a !== 3'b010 ||
          busy_b !== 3'b010 || cnt_a !== 32'd1 || cnt_b !== 4'd1) begin
        failures++;
        $display("FAIL freeze[%0d] got=%b%b %b %b %0d %0d exp=11 010 010 1 1",
                 i, stall_a, stall_b, busy_a, busy_b, cnt_a, cnt_b);
      end
    end
    cpu_en = 1'b1;
    tick();
    checks++;
    if (stall_a !== 1'b0 || cnt_a !== 32'd2 || busy_a !== 3'b100 ||
        stall_b !== 1'b1 || cnt_b !== 4'd2) begin
      failures++;
      $display("FAIL resume1 got=%b %0d %b %b %0d exp=0 2 100 1 2",
               stall_a, cnt_a, busy_a, stall_b, cnt_b);
    end
    tick();
    checks++;
    if (stall_b !== 1'b0 || cnt_b !== 4'd3) begin
      failures++;
      $display("FAIL resume2 got=%b %0d exp=0 3", stall_b, cnt_b);
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    for (int r = 0; r < 7; r++) begin
      set_prod(5'd10);
      tick();
      set_cons(5'd10, 1'b1, 5'd0, 1'b0);
      #1;
      n = 0;
      while ((stall_a || stall_b) && n < 8) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 3) begin
        failures++;
        $display("FAIL sat_round[%0d] got=%0d exp=3 stall cycles", r, n);
      end
      if (r == 3) begin
        checks++;
        if (cnt_a !== 32'd8 || cnt_b !== 4'd12) begin
          failures++;
          $display("FAIL sat_mid got=%0d/%0d exp=8/12", cnt_a, cnt_b);
        end
      end
      idle();
      tick();
    end
    checks++;
    if (cnt_a !== 32'd14 || cnt_b !== 4'd15) begin
      failures++;
      $display("FAIL sat_end got=%0d/%0d exp=14/15", cnt_a, cnt_b);
    end
  endtask

  task automatic test_random();
    bit sa, sb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cpu_en   = ($urandom_range(0, 99) < 85);
      id_valid = ($urandom_range(0, 99) < 80);
      ex_flush = ($urandom_range(0, 99) < 10);
      rs = 5'($urandom_range(0, 3)); rs_used = 1'($urandom);
      rt = 5'($urandom_range(0, 3)); rt_used = 1'($urandom);
      wr = 5'($urandom_range(0, 3)); wr_en = 1'($urandom);
      #1;
      sa = m_stall(qa[0], qa[1], qa[2], 2);
      sb = m_stall(qb[0], qb[1], qb[2], 3);
      checks++;
      if (stall_a !== sa || stall_b !== sb) begin
        failures++;
        $display("FAIL rnd_stall[%0d] got=%b/%b exp=%b/%b", i, stall_a, stall_b, sa, sb);
      end
      checks++;
      if (busy_a !== m_busy(qa[0], qa[1], qa[2]) ||
          busy_b !== m_busy(qb[0], qb[1], qb[2])) begin
        failures++;
        $display("FAIL rnd_busy[%0d] got=%b/%b exp=%b/%b", i, busy_a, busy_b,
                 m_busy(qa[0], qa[1], qa[2]), m_busy(qb[0], qb[1], qb[2]));
      end
      checks++;
      if (cnt_a !== mcnt_a[31:0] || cnt_b !== 4'(mcnt_b)) begin
        failures++;
        $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d/%0d", i, cnt_a, cnt_b, mcnt_a, mcnt_b);
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    idle();
    test_reset();
    test_raw();
    test_rt_zero();
    test_flush();
    test_freeze();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
